// File: rtl/mem_io_ctrl.sv
// Memory/IO address decoder for a small CPU: RAM pass-through below the IO bit,
// and above it a TX FIFO, an RX holding register, a status word and a free-running timer.
module mem_io_ctrl #(
    parameter int WordSize = 16,
    parameter int AddrSize = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AddrSize:0]   addressM,
    input  logic [WordSize-1:0] outM,
    input  logic                writeM,
    output logic [WordSize-1:0] inM,
    output logic [AddrSize-1:0] ram_addr,
    output logic [WordSize-1:0] ram_wdata,
    output logic                ram_we,
    input  logic [WordSize-1:0] ram_rdata,
    output logic [WordSize-1:0] tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [WordSize-1:0] rx_data,
    input  logic                rx_valid,
    output logic                rx_ready
);

    localparam int FifoDepth = 4;
    localparam logic [WordSize-1:0] TimerOne = WordSize'(1);

    // Address decode
    logic       io_sel;
    logic       io_decoded;
    logic [1:0] io_offset;
    logic       wr_tx;
    logic       wr_rx;
    logic       wr_status;
    logic       wr_timer;

    assign io_sel     = addressM[AddrSize];
    assign io_decoded = io_sel && (addressM[AddrSize-1:2] == '0);
    assign io_offset  = addressM[1:0];

    assign wr_tx     = writeM && io_decoded && (io_offset == 2'd0);
    assign wr_rx     = writeM && io_decoded && (io_offset == 2'd1);
    assign wr_status = writeM && io_decoded && (io_offset == 2'd2);
    assign wr_timer  = writeM && io_decoded && (io_offset == 2'd3);

    assign ram_addr  = addressM[AddrSize-1:0];
    assign ram_wdata = outM;
    assign ram_we    = writeM && !io_sel;

    // TX FIFO state
    logic [WordSize-1:0] fifo_mem_reg [FifoDepth];
    logic [1:0]          wr_ptr_reg;
    logic [1:0]          rd_ptr_reg;
    logic [2:0]          count_reg;
    logic [2:0]          count_next;
    logic                overflow_reg;
    logic                tx_full;
    logic                tx_empty;
    logic                tx_pop;
    logic                tx_push;

    assign tx_full  = (count_reg == 3'd4);
    assign tx_empty = (count_reg == 3'd0);
    assign tx_valid = !tx_empty;
    assign tx_data  = fifo_mem_reg[rd_ptr_reg];
    assign tx_pop   = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push  = wr_tx && (!tx_full || tx_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FifoDepth; i++) begin
                fifo_mem_reg[i] <= '0;
            end
        end else if (tx_push) begin
            fifo_mem_reg[wr_ptr_reg] <= outM;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({tx_push, tx_pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (tx_push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (tx_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= count_next;
            if (wr_tx && tx_full && !tx_pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && outM[3]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // RX holding register; while full, an acknowledge only frees the slot
    logic                rx_full_reg;
    logic [WordSize-1:0] rx_hold_reg;

    assign rx_ready = !rx_full_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_full_reg <= 1'b0;
            rx_hold_reg <= '0;
        end else if (rx_valid && !rx_full_reg) begin
            rx_full_reg <= 1'b1;
            rx_hold_reg <= rx_data;
        end else if (wr_rx) begin
            rx_full_reg <= 1'b0;
        end
    end

    // Timer: a load takes priority over the increment
    logic [WordSize-1:0] timer_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_reg <= '0;
        end else if (wr_timer) begin
            timer_reg <= outM;
        end else begin
            timer_reg <= timer_reg + TimerOne;
        end
    end

    // Read path
    logic [WordSize-1:0] status_word;
    logic [WordSize-1:0] io_rdata;

    always_comb begin
        status_word      = '0;
        status_word[0]   = tx_full;
        status_word[1]   = tx_empty;
        status_word[2]   = rx_full_reg;
        status_word[3]   = overflow_reg;
        status_word[6:4] = count_reg;
    end

    always_comb begin
        io_rdata = '0;
        if (io_decoded) begin
            case (io_offset)
                2'd1:    io_rdata = rx_hold_reg;
                2'd2:    io_rdata = status_word;
                2'd3:    io_rdata = timer_reg;
                default: io_rdata = '0;
            endcase
        end
    end

    assign inM = io_sel ? io_rdata : ram_rdata;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl: RAM path, TX FIFO, RX, STATUS, timer, async reset.
module tb_mem_io_ctrl;

    logic        clk;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    int checks;
    int errors;

    mem_io_ctrl #(.WordSize(16), .AddrSize(14)) dut (
        .clk       (clk),
        .reset     (reset),
        .addressM  (addressM),
        .outM      (outM),
        .writeM    (writeM),
        .inM       (inM),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle IO write; starts just after a negedge and returns at the next negedge.
    task automatic write_io(input logic [1:0] off, input logic [15:0] data);
        addressM = {1'b1, 12'd0, off};
        outM     = data;
        writeM   = 1'b1;
        @(negedge clk);
        writeM   = 1'b0;
    endtask

    task automatic read_io(input logic [1:0] off, output logic [15:0] data);
        addressM = {1'b1, 12'd0, off};
        writeM   = 1'b0;
        #1;
        data = inM;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0h want 0", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL reset_tx_data got %04h want 0000", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %0h want 1", rx_ready); end
        @(negedge clk);
        reset = 1'b1;
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL reset_status got %04h want 0002", rd); end
        read_io(2'd0, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL reset_txdata_read got %04h want 0000", rd); end
        $display("test_reset done");
    endtask

    task automatic test_ram();
        @(negedge clk);
        ram_rdata = 16'h5555;
        addressM  = 15'h0005;
        outM      = 16'h1234;
        writeM    = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ram_we_low got %0h want 1", ram_we); end
        checks++; if (ram_addr !== 14'd5) begin errors++; $display("FAIL ram_addr got %0h want 5", ram_addr); end
        checks++; if (ram_wdata !== 16'h1234) begin errors++; $display("FAIL ram_wdata got %04h want 1234", ram_wdata); end
        checks++; if (inM !== 16'h5555) begin errors++; $display("FAIL ram_inM got %04h want 5555", inM); end
        addressM = 15'h4000;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ram_we_io got %0h want 0", ram_we); end
        writeM = 1'b0;
        $display("test_ram done");
    endtask

    task automatic test_unmapped();
        logic [15:0] rd;
        @(negedge clk);
        addressM = 15'h4006;
        #1;
        checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %04h want 0000", inM); end
        addressM = 15'h4004;
        outM     = 16'h7777;
        writeM   = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL unmapped_ram_we got %0h want 0", ram_we); end
        @(negedge clk);
        writeM = 1'b0;
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL unmapped_status got %04h want 0002", rd); end
        $display("test_unmapped done");
    endtask

    task automatic test_fifo_overflow();
        logic [15:0] rd;
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h000A; exp_q[1] = 16'h000B; exp_q[2] = 16'h000C; exp_q[3] = 16'h000D;
        @(negedge clk);
        tx_ready = 1'b0;
        write_io(2'd0, 16'h000A);
        write_io(2'd0, 16'h000B);
        write_io(2'd0, 16'h000C);
        write_io(2'd0, 16'h000D);
        write_io(2'd0, 16'h000E);
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0049) begin errors++; $display("FAIL fifo_full_status got %04h want 0049", rd); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin errors++; $display("FAIL fifo_drain_%0d got v=%0h d=%04h want v=1 d=%04h", i, tx_valid, tx_data, exp_q[i]); end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty_valid got %0h want 0", tx_valid); end
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL fifo_empty_status got %04h want 000A", rd); end
        @(negedge clk);
        write_io(2'd2, 16'hFFF7);
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL ovf_keep_status got %04h want 000A", rd); end
        @(negedge clk);
        write_io(2'd2, 16'h0008);
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL ovf_clear_status got %04h want 0002", rd); end
        $display("test_fifo_overflow done");
    endtask

    task automatic test_full_push_pop();
        logic [15:0] rd;
        logic [15:0] exp_q [4];
        exp_q[0] = 16'h0002; exp_q[1] = 16'h0003; exp_q[2] = 16'h0004; exp_q[3] = 16'h000F;
        @(negedge clk);
        tx_ready = 1'b0;
        write_io(2'd0, 16'h0001);
        write_io(2'd0, 16'h0002);
        write_io(2'd0, 16'h0003);
        write_io(2'd0, 16'h0004);
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0041) begin errors++; $display("FAIL pp_full_status got %04h want 0041", rd); end
        @(negedge clk);
        tx_ready = 1'b1;
        write_io(2'd0, 16'h000F);
        tx_ready = 1'b0;
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0041) begin errors++; $display("FAIL pp_after_status got %04h want 0041", rd); end
        checks++; if (tx_data !== 16'h0002) begin errors++; $display("FAIL pp_head got %04h want 0002", tx_data); end
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin errors++; $display("FAIL pp_drain_%0d got v=%0h d=%04h want v=1 d=%04h", i, tx_valid, tx_data, exp_q[i]); end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL pp_end_status got %04h want 0002", rd); end
        $display("test_full_push_pop done");
    endtask

    task automatic test_rx();
        logic [15:0] rd;
        @(negedge clk);
        rx_data  = 16'hBEEF;
        rx_valid = 1'b1;
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_before got %0h want 1", rx_ready); end
        @(negedge clk);
        rx_data = 16'h1111;
        #1;
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got %0h want 0", rx_ready); end
        read_io(2'd1, rd);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rx_hold_first got %04h want BEEF", rd); end
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0006) begin errors++; $display("FAIL rx_status got %04h want 0006", rd); end
        @(negedge clk);
        read_io(2'd1, rd);
        checks++; if (rd !== 16'hBEEF || rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ignore got %04h rdy=%0h want BEEF rdy=0", rd, rx_ready); end
        @(negedge clk);
        write_io(2'd1, 16'h0000);
        read_io(2'd1, rd);
        checks++; if (rx_ready !== 1'b1 || rd !== 16'hBEEF) begin errors++; $display("FAIL rx_ack_collide got rdy=%0h d=%04h want rdy=1 d=BEEF", rx_ready, rd); end
        @(negedge clk);
        rx_valid = 1'b0;
        read_io(2'd1, rd);
        checks++; if (rx_ready !== 1'b0 || rd !== 16'h1111) begin errors++; $display("FAIL rx_second got rdy=%0h d=%04h want rdy=0 d=1111", rx_ready, rd); end
        @(negedge clk);
        write_io(2'd1, 16'hABCD);
        #1;
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ack got %0h want 1", rx_ready); end
        $display("test_rx done");
    endtask

    task automatic test_timer();
        logic [15:0] rd;
        @(negedge clk);
        write_io(2'd3, 16'hFFFE);
        read_io(2'd3, rd);
        checks++; if (rd !== 16'hFFFE) begin errors++; $display("FAIL timer_load got %04h want FFFE", rd); end
        @(negedge clk);
        read_io(2'd3, rd);
        checks++; if (rd !== 16'hFFFF) begin errors++; $display("FAIL timer_inc got %04h want FFFF", rd); end
        @(negedge clk);
        read_io(2'd3, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL timer_wrap got %04h want 0000", rd); end
        $display("test_timer done");
    endtask

    task automatic test_async_reset();
        logic [15:0] rd;
        @(negedge clk);
        tx_ready = 1'b0;
        write_io(2'd0, 16'h0101);
        write_io(2'd0, 16'h0202);
        write_io(2'd0, 16'h0303);
        rx_data  = 16'h5A5A;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0034) begin errors++; $display("FAIL ar_pre_status got %04h want 0034", rd); end
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || tx_data !== 16'h0000) begin errors++; $display("FAIL ar_outputs got v=%0h rdy=%0h d=%04h want v=0 rdy=1 d=0000", tx_valid, rx_ready, tx_data); end
        read_io(2'd2, rd);
        checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL ar_status got %04h want 0002", rd); end
        read_io(2'd1, rd);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ar_rxhold got %04h want 0000", rd); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_io(2'd3, rd);
        checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL ar_resume_timer got %04h want 0001", rd); end
        $display("test_async_reset done");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        addressM  = '0;
        outM      = '0;
        writeM    = 1'b0;
        ram_rdata = '0;
        tx_ready  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        test_reset();
        test_ram();
        test_unmapped();
        test_fifo_overflow();
        test_full_push_pop();
        test_rx();
        test_timer();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter WordSize, default 16, data word width.
REQ-002 SHALL have parameter AddrSize, default 14, RAM address width; the CPU address is AddrSize+1 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port addressM  input  AddrSize+1  CPU data address; MSB 1 = IO region.
REQ-006 SHALL have port outM  input  WordSize  CPU write data.
REQ-007 SHALL have port writeM  input  1  CPU write strobe.
REQ-008 SHALL have port inM  output  WordSize  read data returned to the CPU.
REQ-009 SHALL have port ram_addr  output  AddrSize  RAM address, equal to addressM[AddrSize-1:0].
REQ-010 SHALL have ports ram_wdata (output, WordSize, equal to outM), ram_we (output, 1) and ram_rdata (input, WordSize, combinational RAM read).
REQ-011 SHALL have ports tx_data (output, WordSize), tx_valid (output, 1) and tx_ready (input, 1); together they form the output-stream handshake.
REQ-012 SHALL have ports rx_data (input, WordSize), rx_valid (input, 1) and rx_ready (output, 1); together they form the input-stream handshake.

Function
REQ-013 SHALL drive ram_we = writeM AND NOT addressM[AddrSize].
REQ-014 SHALL make inM combinational: ram_rdata when the MSB is 0; otherwise the IO register selected by offset addressM[1:0].
REQ-015 SHALL decode only offsets 0-3 in the IO region; IO addresses with nonzero bits [AddrSize-1:2] SHALL read 0 and ignore writes.
REQ-016 Offset 0 (TXDATA): a write SHALL push outM into a 4-entry TX FIFO; a read SHALL return 0.
REQ-017 Offset 1 (RXDATA): a read SHALL return the RX holding register; a write (any data) SHALL clear rx_full at the next edge.
REQ-018 Offset 2 (STATUS): a read SHALL return bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 tx_overflow, bits6:4 tx_count (0-4), and all other bits 0.
REQ-019 Offset 2 (STATUS): a write with outM[3]=1 SHALL clear tx_overflow; other data bits SHALL be ignored.
REQ-020 Offset 3 (TIMER): the counter SHALL be WordSize wide, increment every cycle and wrap from all-ones to 0.
REQ-021 Offset 3 (TIMER): a write SHALL load outM; the load SHALL win over the increment that cycle; the counter SHALL read outM the next cycle and outM+1 the cycle after.
REQ-022 TX FIFO: tx_valid = NOT empty; tx_data = head entry (registered storage); pop when tx_valid AND tx_ready.
REQ-023 TX FIFO push while full without a same-cycle pop: data SHALL be dropped, tx_overflow SHALL set (sticky), and count SHALL be unchanged.
REQ-024 TX FIFO push and pop in the same cycle: both SHALL occur, count SHALL be unchanged, and this SHALL hold when full (no overflow) and when empty is impossible since a pop needs tx_valid.
REQ-025 TX FIFO read/write pointers SHALL be 2-bit and wrap modulo 4; order SHALL be strictly first-in first-out.
REQ-026 RX: rx_ready = NOT rx_full.
REQ-027 RX: when rx_valid AND rx_ready, rx_data SHALL be captured and rx_full set at the edge.
REQ-028 RX: rx_valid while full SHALL be ignored.
REQ-029 RX: an RXDATA acknowledge in the same cycle as rx_valid with rx_full=1 SHALL only clear rx_full; the new word is accepted on a later cycle.
REQ-030 A write to any IO address SHALL NOT assert ram_we.
REQ-031 A read (writeM=0) SHALL never change any state.

Reset
REQ-032 On reset low, the block SHALL immediately clear the FIFO pointers and count, tx_overflow, rx_full, the RX holding register, the timer and the FIFO storage.
REQ-033 After reset, outputs SHALL be tx_valid=0, tx_data=0 and rx_ready=1; inM and ram_* SHALL follow their inputs combinationally.
REQ-034 Reset asserted mid-transfer SHALL discard queued TX data and any pending RX word, with no partial handshake completing.
REQ-035 Operation SHALL resume on the first posedge clk after reset deasserts.

Verification
REQ-036 RAM path: addressM=0x0005, writeM=1, outM=0x1234 -> ram_we=1, ram_addr=5, ram_wdata=0x1234; addressM=0x4000, writeM=1 -> ram_we=0.
REQ-037 FIFO fill/overflow: tx_ready=0, push 0xA,0xB,0xC,0xD,0xE -> STATUS=0x0049 (count 4, full, overflow); raise tx_ready -> tx_data sequence 0xA,0xB,0xC,0xD, then tx_valid=0 and STATUS=0x000A.
REQ-038 Full push+pop: FIFO full, tx_ready=1 and push 0xF in the same cycle -> count stays 4, no overflow, 0xF drains last.
REQ-039 RX: rx_valid=1, rx_data=0xBEEF -> rx_ready=0 next cycle and RXDATA reads 0xBEEF; a second rx_valid with 0x1111 is ignored; write RXDATA -> rx_ready=1.
REQ-040 Timer: write 0xFFFE to TIMER -> reads 0xFFFE, 0xFFFF, 0x0000 on consecutive cycles.
REQ-041 Async reset: with 3 queued TX words and rx_full=1, pulse reset low between clock edges -> tx_valid=0 and rx_ready=1 immediately, and STATUS=0x0002.
